// File: rtl/qe_gen_if.sv
// qe_gen bus: move command (target/period/load) and generator status.
// Optional z index pulse exists only when QE_GEN_INDEX_EN is defined.
interface qe_gen_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic [WIDTH-1:0] target;
  logic [DIV_W-1:0] period;
  logic             load;
  logic             i;
  logic             q;
  logic [WIDTH-1:0] pos;
  logic             busy;
  logic             done;
`ifdef QE_GEN_INDEX_EN
  logic             z;

  modport master (
    output target, period, load,
    input  i, q, pos, busy, done, z
  );

  modport slave (
    input  target, period, load,
    output i, q, pos, busy, done, z
  );
`else
  modport master (
    output target, period, load,
    input  i, q, pos, busy, done
  );

  modport slave (
    input  target, period, load,
    output i, q, pos, busy, done
  );
`endif
endinterface

// File: rtl/qe_gen.sv
// qe_gen: quadrature i/q generator stepping pos toward a target.
// Ports: clk, clr (sync high), bus (slave: target/period/load in;
// i/q/pos/busy/done out, z when QE_GEN_INDEX_EN is defined).
module qe_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic     clk,
  input  logic     clr,
  qe_gen_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] P_ONE = WIDTH'(1);
  localparam logic [DIV_W-1:0] D_ONE = DIV_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;
  logic             i_q, q_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] pos_step;
  logic             at_tgt;
  logic             step;
`ifdef QE_GEN_INDEX_EN
  logic             z_q, z_d;
`endif

  // Signed tgt-pos: msb clear means forward; the half-range
  // tie (msb set, rest zero) therefore goes reverse.
  assign diff     = tgt_q - pos_q;
  assign at_tgt   = (pos_q == tgt_q);
  assign pos_step = diff[WIDTH-1] ? pos_q - P_ONE
                                  : pos_q + P_ONE;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    per_d   = per_q;
    div_d   = div_q;
    done_d  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          tgt_d   = bus.target;
          per_d   = bus.period;
          div_d   = bus.period;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.load) begin
          // Retarget; a move finishing now still reports done.
          tgt_d  = bus.target;
          per_d  = bus.period;
          div_d  = bus.period;
          done_d = at_tgt;
        end else if (at_tgt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (div_q == '0) begin
          step  = 1'b1;
          pos_d = pos_step;
          div_d = per_q;
        end else begin
          div_d = div_q - D_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef QE_GEN_INDEX_EN
  // Index only follows landed steps, so reset at 0 keeps z low.
  always_comb begin
    z_d = z_q;
    if (step) begin
      z_d = (pos_d == '0);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      pos_q   <= '0;
      tgt_q   <= '0;
      per_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
      i_q     <= 1'b0;
      q_q     <= 1'b0;
`ifdef QE_GEN_INDEX_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      per_q   <= per_d;
      div_q   <= div_d;
      done_q  <= done_d;
      // Phases registered from next pos: glitch-free i/q.
      i_q     <= pos_d[1] ^ pos_d[0];
      q_q     <= pos_d[1];
`ifdef QE_GEN_INDEX_EN
      z_q     <= z_d;
`endif
    end
  end

  assign bus.pos  = pos_q;
  assign bus.i    = i_q;
  assign bus.q    = q_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
`ifdef QE_GEN_INDEX_EN
  assign bus.z    = z_q;
`endif
endmodule

// File: tb/tb_qe_gen.sv
// tb_qe_gen: directed bench with cycle model and literal checks.
// Build with +define+QE_GEN_INDEX_EN to cover the index output.
module tb_qe_gen;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  qe_gen_if #(.WIDTH(W), .DIV_W(D)) bus();

  qe_gen #(.WIDTH(W), .DIV_W(D)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: position/target as plain integers mod 256.
  int m_pos = 0, m_tgt = 0, m_per = 0, m_cnt = 0;
  bit m_busy = 0, m_done = 0, m_z = 0;

  function automatic int nxt(input int p, input int t);
    int d;
    d = (t - p) & 255;
    return (d < 128) ? ((p + 1) & 255) : ((p + 255) & 255);
  endfunction

  // Forward sequence 00,10,11,01 indexed by pos mod 4.
  function automatic logic [1:0] iq_of(input int p);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b10, 2'b11, 2'b01};
    return tbl[p & 3];
  endfunction

  always @(posedge clk) begin
    int np;
    if (clr) begin
      m_pos <= 0; m_tgt <= 0; m_per <= 0; m_cnt <= 0;
      m_busy <= 0; m_done <= 0; m_z <= 0;
    end else begin
      m_done <= 0;
      if (bus.load) begin
        m_done <= m_busy && (m_pos == m_tgt);
        m_tgt  <= int'(bus.target);
        m_per  <= int'(bus.period);
        m_cnt  <= int'(bus.period) + 1;
        m_busy <= 1;
      end else if (m_busy) begin
        if (m_pos == m_tgt) begin
          m_busy <= 0;
          m_done <= 1;
        end else if (m_cnt == 1) begin
          np = nxt(m_pos, m_tgt);
          m_pos <= np;
          m_z   <= (np == 0);
          m_cnt <= m_per + 1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pos", 32'(bus.pos), 32'(m_pos));
      chk("iq", 32'({bus.i, bus.q}), 32'(iq_of(m_pos)));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
`ifdef QE_GEN_INDEX_EN
      chk("z", 32'(bus.z), 32'(m_z));
`endif
    end
  end

  task automatic do_clr(input int n);
    clr = 1'b1;
    repeat (n) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load_mv(input int t, input int p);
    bus.target = W'(t);
    bus.period = D'(p);
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_idle(input int maxc,
                           output int nd,
                           output int nf);
    int prev;
    bit ok;
    nd = 0; nf = 0; ok = 0;
    prev = int'(bus.pos);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (int'(bus.pos) == ((prev + 1) & 255)) nf++;
      prev = int'(bus.pos);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got busy expected idle");
    end
  endtask

  task automatic wait_pos(input int p, input int maxc);
    bit ok;
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (int'(bus.pos) == p) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_pos: got %0d expected %0d",
               bus.pos, p);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nd, nf, zc, ep;
    logic [1:0] iq_exp [5];
    iq_exp = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    clr = 1'b1;
    bus.load = 1'b0;
    bus.target = '0;
    bus.period = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("rst_pos", 32'(bus.pos), 0);
    chk("rst_iq", 32'({bus.i, bus.q}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);

    // Forward 0->4, period 2: steps at n=3,6,9,12, done n=13.
    load_mv(4, 2);
    nd = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      ep = (n / 3 > 4) ? 4 : n / 3;
      chk("fwd_pos", 32'(bus.pos), 32'(ep));
      chk("fwd_iq", 32'({bus.i, bus.q}), 32'(iq_exp[ep]));
      if (bus.done) nd++;
      if (n == 13) chk("fwd_done13", 32'(bus.done), 1);
      if (n == 13) chk("fwd_busy13", 32'(bus.busy), 0);
    end
    chk("fwd_ndone", 32'(nd), 1);

    // Reverse with wrap: 0 -> 255 -> 254.
    do_clr(1);
    load_mv(254, 0);
    @(negedge clk);
    chk("rev_p1", 32'(bus.pos), 255);
    chk("rev_iq1", 32'({bus.i, bus.q}), 32'(2'b01));
    @(negedge clk);
    chk("rev_p2", 32'(bus.pos), 254);
    chk("rev_iq2", 32'({bus.i, bus.q}), 32'(2'b11));
    @(negedge clk);
    chk("rev_done", 32'(bus.done), 1);
    @(negedge clk);
    chk("rev_done_off", 32'(bus.done), 0);

    // Load with target==pos: done next edge, pos unchanged.
    load_mv(254, 3);
    @(negedge clk);
    chk("same_done", 32'(bus.done), 1);
    chk("same_pos", 32'(bus.pos), 254);
    chk("same_busy", 32'(bus.busy), 0);

    // Half-range tie goes reverse all the way.
    do_clr(1);
    load_mv(128, 0);
    wait_idle(300, nd, nf);
    chk("tie_pos", 32'(bus.pos), 128);
    chk("tie_nfwd", 32'(nf), 0);
    chk("tie_ndone", 32'(nd), 1);

    // Retarget at pos 3 back to 1.
    do_clr(1);
    load_mv(10, 1);
    wait_pos(3, 50);
    load_mv(1, 1);
    wait_idle(50, nd, nf);
    chk("rt_pos", 32'(bus.pos), 1);
    chk("rt_ndone", 32'(nd), 1);

    // clr mid-move at pos 5.
    do_clr(1);
    load_mv(10, 1);
    wait_pos(5, 50);
    do_clr(1);
    chk("clr_pos", 32'(bus.pos), 0);
    chk("clr_iq", 32'({bus.i, bus.q}), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("clr_ndone", 32'(nd), 0);

`ifdef QE_GEN_INDEX_EN
    do_clr(1);
    chk("z_rst", 32'(bus.z), 0);
    load_mv(2, 0);
    wait_idle(20, nd, nf);
    chk("z_at2", 32'(bus.z), 0);
    load_mv(254, 0);
    zc = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (bus.z) zc++;
      if (n == 2) chk("z_at0", 32'(bus.z), 1);
      if (n == 3) chk("z_at255", 32'(bus.z), 0);
    end
    chk("z_count", 32'(zc), 1);
`else
    zc = 0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
